// File: rtl/digipot_pkg.sv
// Shared types and defaults for the digipot command sequencer.
package digipot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STROBE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] pot;
        logic [7:0] val;
    } cmd_t;

    localparam logic [1:0]  POT_NONE        = 2'd3;
    localparam int unsigned CMD_W           = 10;
    localparam int unsigned DEPTH_DEF       = 4;
    localparam int unsigned CTRL_LOW_DEF    = 4;
    localparam int unsigned HOLD_CYCLES_DEF = 48;

endpackage

// File: rtl/digipot_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally on rdata_c.
module digipot_cmd_fifo
    import digipot_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  cmd_t wdata,
    output cmd_t rdata_c,
    output logic full,
    output logic empty,
    output logic empty_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic          do_push, do_pop, full_d;
    cmd_t          mem [DEPTH];

    // Next pointers; the extra MSB separates full from empty.
    always_comb begin
        do_push     = push && !full;
        do_pop      = pop && !empty;
        wr_ptr_d    = wr_ptr + PW'(do_push);
        rd_ptr_d    = rd_ptr + PW'(do_pop);
        full_d      = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_nxt_c = (wr_ptr_d == rd_ptr_d);
        rdata_c     = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            full   <= full_d;
            empty  <= empty_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/digipot_cmd_seq.sv
// Queues pot-write commands and presents them to the SPI serializer one at a time.
module digipot_cmd_seq
    import digipot_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned CTRL_LOW    = CTRL_LOW_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_pot,
    input  logic [7:0] wr_val,
    output logic       full,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       bad_pot,
    output logic [1:0] mux,
    output logic [7:0] dato,
    output logic       ctrl
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [1:0]         mux_d;
    logic [7:0]         dato_d;
    logic               ctrl_d, done_d, busy_d, overflow_d, bad_pot_d;
    logic               push, pop, empty, empty_nxt;
    logic               pot_ok;
    cmd_t               head;

    digipot_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .wdata       ({wr_pot, wr_val}),
        .rdata_c     (head),
        .full        (full),
        .empty       (empty),
        .empty_nxt_c (empty_nxt)
    );

    // A full FIFO drops the write even when a pop happens in the same cycle.
    always_comb begin
        pot_ok     = (wr_pot != POT_NONE);
        push       = wr_en && pot_ok && !full;
        overflow_d = overflow || (wr_en && pot_ok && full);
        bad_pot_d  = bad_pot || (wr_en && !pot_ok);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        mux_d   = mux;
        dato_d  = dato;
        pop     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                mux_d = POT_NONE;
                if (!empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop     = 1'b1;
                mux_d   = head.pot;
                dato_d  = head.val;
                cnt_d   = CNT_W'(CTRL_LOW - 1);
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    cnt_d   = CNT_W'(HOLD_CYCLES - CTRL_LOW - 1);
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) state_d = ST_DONE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            ST_DONE: begin
                if (!empty) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    mux_d   = POT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mux_d   = POT_NONE;
            end
        endcase
        ctrl_d = (state_d != ST_STROBE);
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE) || !empty_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mux      <= POT_NONE;
            dato     <= '0;
            ctrl     <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            bad_pot  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            mux      <= mux_d;
            dato     <= dato_d;
            ctrl     <= ctrl_d;
            done     <= done_d;
            busy     <= busy_d;
            overflow <= overflow_d;
            bad_pot  <= bad_pot_d;
        end
    end

endmodule

// File: tb/tb_digipot_cmd_seq.sv
// Directed bench for digipot_cmd_seq: cycle-exact vector table plus multi-command sequences.
module tb_digipot_cmd_seq;
    import digipot_pkg::*;

    localparam int unsigned HOLD = 48;
    localparam int unsigned CL   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_pot;
    logic [7:0] wr_val;
    logic       full, busy, done, overflow, bad_pot, ctrl;
    logic [1:0] mux;
    logic [7:0] dato;

    int n_vec = 0;
    int n_bad = 0;

    digipot_cmd_seq #(.DEPTH(4), .CTRL_LOW(CL), .HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_pot   (wr_pot),
        .wr_val   (wr_val),
        .full     (full),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bad_pot  (bad_pot),
        .mux      (mux),
        .dato     (dato),
        .ctrl     (ctrl)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit          start;
        int          cyc;
        bit          we;
        logic [1:0]  pot;
        logic [7:0]  val;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic [1:0] wp [8];
    logic [7:0] wv [8];
    int         n_wr, n_exp;

    function automatic logic [15:0] pk(input logic [1:0] m, input logic [7:0] d,
                                       input logic c, input logic dn, input logic b,
                                       input logic f, input logic o, input logic bp);
        return {m, d, c, dn, b, f, o, bp};
    endfunction

    function automatic logic [15:0] obs();
        return {mux, dato, ctrl, done, busy, full, overflow, bad_pot};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input logic [1:0] p, input logic [7:0] v);
        wr_en  = we;
        wr_pot = p;
        wr_val = v;
    endtask

    // After this task the next clock edge is edge 0.
    task automatic do_reset();
        drive(1'b0, 2'd0, 8'd0);
        rst = 1'b1;
        tick(); tick(); tick();
        chk("reset_state", 32'(obs()), 32'(pk(2'd3, 8'h00, 1, 0, 0, 0, 0, 0)));
        rst = 1'b0;
    endtask

    task automatic add(input bit s, input int c, input bit we, input logic [1:0] p,
                       input logic [7:0] v, input logic [15:0] e);
        vec_t r;
        r.start = s; r.cyc = c; r.we = we; r.pot = p; r.val = v; r.exp = e;
        vecs.push_back(r);
    endtask

    // Runs writes wp/wv at edges 0..n_wr-1 and watches transfers with a serializer model.
    task automatic run_seq(input string nm, input int budget);
        int         done_cnt = 0;
        int         falls = 0;
        int         since = -1;
        int         stab_err = 0;
        int         gap_err = 0;
        int         fall_c[8];
        logic [1:0] hmux = 2'd3;
        logic [7:0] word = 8'd0;
        logic [2:0] bi;
        logic       prev_ctrl = 1'b1;
        bit         fin = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            if (c < n_wr) drive(1'b1, wp[c], wv[c]);
            else          drive(1'b0, 2'd0, 8'd0);
            tick();
            if (prev_ctrl && !ctrl) begin
                if (falls < 8) fall_c[falls] = c;
                falls++;
                since = 0;
                hmux  = mux;
                word  = 8'd0;
            end else if (since >= 0) begin
                since++;
            end
            if (since >= 0 && since < int'(HOLD) && mux !== hmux) stab_err++;
            if (since >= 4 && since <= 32 && since % 4 == 0) begin
                bi   = 3'(7 - (since - 4) / 4);
                word = {word[6:0], dato[bi]};
            end
            if (since == 32 && falls <= n_exp)
                chk($sformatf("%s_frame%0d", nm, falls - 1), 32'({hmux, word}),
                    32'({wp[falls-1], wv[falls-1]}));
            if (done) done_cnt++;
            if (falls > 0 && done_cnt < n_exp && mux === POT_NONE) gap_err++;
            prev_ctrl = ctrl;
            if (done_cnt == n_exp && !busy && c > n_wr) fin = 1'b1;
        end
        chk({nm, "_finished"}, 32'(fin), 32'd1);
        chk({nm, "_done_cnt"}, 32'(done_cnt), 32'(n_exp));
        chk({nm, "_falls"}, 32'(falls), 32'(n_exp));
        if (falls > 0) chk({nm, "_first_fall"}, 32'(fall_c[0]), 32'd2);
        for (int k = 1; k < n_exp && k < falls && k < 8; k++)
            chk($sformatf("%s_spacing%0d", nm, k), 32'(fall_c[k] - fall_c[k-1]), 32'(HOLD + 2));
        chk({nm, "_mux_stable"}, 32'(stab_err), 32'd0);
        chk({nm, "_no_gap"}, 32'(gap_err), 32'd0);
    endtask

    initial begin
        int edge_n = 0;
        int errs;
        rst = 1'b1;
        drive(1'b0, 2'd0, 8'd0);

        // Single write (pot 1, 0xA5)
        add(1,  0, 1, 2'd1, 8'hA5, pk(2'd3, 8'h00, 1, 0, 1, 0, 0, 0));
        add(0,  1, 0, 2'd0, 8'h00, pk(2'd3, 8'h00, 1, 0, 1, 0, 0, 0));
        add(0,  2, 0, 2'd0, 8'h00, pk(2'd1, 8'hA5, 0, 0, 1, 0, 0, 0));
        add(0,  5, 0, 2'd0, 8'h00, pk(2'd1, 8'hA5, 0, 0, 1, 0, 0, 0));
        add(0,  6, 0, 2'd0, 8'h00, pk(2'd1, 8'hA5, 1, 0, 1, 0, 0, 0));
        add(0, 49, 0, 2'd0, 8'h00, pk(2'd1, 8'hA5, 1, 0, 1, 0, 0, 0));
        add(0, 50, 0, 2'd0, 8'h00, pk(2'd1, 8'hA5, 1, 1, 1, 0, 0, 0));
        add(0, 51, 0, 2'd0, 8'h00, pk(2'd3, 8'hA5, 1, 0, 0, 0, 0, 0));
        add(0, 52, 0, 2'd0, 8'h00, pk(2'd3, 8'hA5, 1, 0, 0, 0, 0, 0));
        // Illegal pot index
        add(1,  0, 1, 2'd3, 8'hFF, pk(2'd3, 8'h00, 1, 0, 0, 0, 0, 1));
        add(0,  3, 0, 2'd0, 8'h00, pk(2'd3, 8'h00, 1, 0, 0, 0, 0, 1));
        add(0, 10, 0, 2'd0, 8'h00, pk(2'd3, 8'h00, 1, 0, 0, 0, 0, 1));
        // Six back-to-back writes into a depth-4 FIFO
        add(1,  0, 1, 2'd0, 8'h61, pk(2'd3, 8'h00, 1, 0, 1, 0, 0, 0));
        add(0,  1, 1, 2'd1, 8'h62, pk(2'd3, 8'h00, 1, 0, 1, 0, 0, 0));
        add(0,  2, 1, 2'd2, 8'h63, pk(2'd0, 8'h61, 0, 0, 1, 0, 0, 0));
        add(0,  3, 1, 2'd0, 8'h64, pk(2'd0, 8'h61, 0, 0, 1, 0, 0, 0));
        add(0,  4, 1, 2'd1, 8'h65, pk(2'd0, 8'h61, 0, 0, 1, 1, 0, 0));
        add(0,  5, 1, 2'd2, 8'h66, pk(2'd0, 8'h61, 0, 0, 1, 1, 1, 0));
        add(0,  6, 0, 2'd0, 8'h00, pk(2'd0, 8'h61, 1, 0, 1, 1, 1, 0));
        // Illegal pot while full: only bad_pot is set
        add(1,  0, 1, 2'd0, 8'h71, pk(2'd3, 8'h00, 1, 0, 1, 0, 0, 0));
        add(0,  1, 1, 2'd1, 8'h72, pk(2'd3, 8'h00, 1, 0, 1, 0, 0, 0));
        add(0,  2, 1, 2'd2, 8'h73, pk(2'd0, 8'h71, 0, 0, 1, 0, 0, 0));
        add(0,  3, 1, 2'd0, 8'h74, pk(2'd0, 8'h71, 0, 0, 1, 0, 0, 0));
        add(0,  4, 1, 2'd1, 8'h75, pk(2'd0, 8'h71, 0, 0, 1, 1, 0, 0));
        add(0,  5, 1, 2'd3, 8'h76, pk(2'd0, 8'h71, 0, 0, 1, 1, 0, 1));

        foreach (vecs[i]) begin
            if (vecs[i].start) begin
                do_reset();
                edge_n = 0;
            end
            while (edge_n < vecs[i].cyc) begin
                drive(1'b0, 2'd0, 8'd0);
                tick();
                edge_n++;
            end
            drive(vecs[i].we, vecs[i].pot, vecs[i].val);
            tick();
            edge_n++;
            drive(1'b0, 2'd0, 8'd0);
            chk($sformatf("vec%0d_c%0d", i, vecs[i].cyc), 32'(obs()), 32'(vecs[i].exp));
        end

        // Three consecutive writes to pots 0, 1, 2
        do_reset();
        wp[0] = 2'd0; wv[0] = 8'h11;
        wp[1] = 2'd1; wv[1] = 8'h22;
        wp[2] = 2'd2; wv[2] = 8'h33;
        n_wr = 3; n_exp = 3;
        run_seq("b2b3", 250);

        // Six writes, sixth dropped on overflow
        do_reset();
        for (int k = 0; k < 6; k++) begin
            wp[k] = 2'(k % 3);
            wv[k] = 8'(8'h61 + k);
        end
        n_wr = 6; n_exp = 5;
        run_seq("ovf6", 400);
        chk("ovf6_overflow_sticky", 32'(overflow), 32'd1);
        chk("ovf6_bad_pot_clear", 32'(bad_pot), 32'd0);

        // Reset in cycle 20 of a transfer flushes the queue
        do_reset();
        wp[0] = 2'd2; wv[0] = 8'h3C;
        wp[1] = 2'd3; wv[1] = 8'hFF;
        wp[2] = 2'd0; wv[2] = 8'h01;
        wp[3] = 2'd1; wv[3] = 8'h02;
        for (int c = 0; c <= 20; c++) begin
            if (c < 4) drive(1'b1, wp[c], wv[c]);
            else       drive(1'b0, 2'd0, 8'd0);
            tick();
        end
        chk("rst_pre_c20", 32'(obs()), 32'(pk(2'd2, 8'h3C, 1, 0, 1, 0, 0, 1)));
        rst = 1'b1;
        tick();
        chk("rst_mid_c21", 32'(obs()), 32'(pk(2'd3, 8'h00, 1, 0, 0, 0, 0, 0)));
        rst = 1'b0;
        errs = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (ctrl !== 1'b1 || busy !== 1'b0 || mux !== 2'd3) errs++;
        end
        chk("rst_flushed", 32'(errs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
